// File: rtl/miner_event_gen.sv
// Miner status event generator: job FSM with idle watchdog, core-load hold-off
// on work_ready, and a 2-entry result FIFO between core strobes and the transmitter.
module miner_event_gen #(
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16777215,
    parameter int unsigned LOAD_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               work_valid,
    output logic               work_ready,
    input  logic               nonce_found,
    input  logic [NONCE_W-1:0] nonce_in,
    input  logic               range_done,
    output logic               result_valid,
    output logic [NONCE_W-1:0] result_nonce,
    input  logic               result_ready,
    output logic               new_work,
    output logic               new_result,
    output logic               hashing,
    output logic               overflow,
    output logic [15:0]        found_count
);

    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LOAD_W = $clog2(LOAD_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOAD_W-1:0] LOAD_INIT = LOAD_W'(LOAD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HASHING,
        S_EXHAUSTED
    } state_t;

    state_t             state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [LOAD_W-1:0]  load_cnt;
    logic [1:0]         fill;
    logic [NONCE_W-1:0] tail;

    logic accept;
    logic pop;
    logic honoured;
    logic full;
    logic push;

    assign accept   = work_valid & work_ready;
    assign pop      = result_valid & result_ready;
    // A nonce arriving with a job accept belongs to the job being (re)started.
    assign honoured = nonce_found & ((state == S_HASHING) | accept);
    assign full     = (fill == 2'd2);
    assign push     = honoured & (~full | pop);

    // Job FSM, idle watchdog and core-load hold-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            hashing    <= 1'b0;
            new_work   <= 1'b0;
            work_ready <= 1'b0;
            tmo_cnt    <= '0;
            load_cnt   <= '0;
        end else begin
            new_work <= accept;

            if (accept) begin
                load_cnt   <= LOAD_INIT;
                work_ready <= 1'b0;
            end else if (load_cnt > LOAD_W'(1)) begin
                load_cnt <= load_cnt - LOAD_W'(1);
            end else begin
                load_cnt   <= '0;
                work_ready <= 1'b1;
            end

            if (accept) begin
                state   <= S_HASHING;
                hashing <= 1'b1;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    S_HASHING: begin
                        if (range_done) begin
                            state   <= S_EXHAUSTED;
                            hashing <= 1'b0;
                            tmo_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state   <= S_IDLE;
                            hashing <= 1'b0;
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    default: begin
                        hashing <= 1'b0;
                        tmo_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Result FIFO: result_nonce is the head register, tail holds the second entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill         <= 2'd0;
            tail         <= '0;
            result_nonce <= '0;
            result_valid <= 1'b0;
            new_result   <= 1'b0;
            overflow     <= 1'b0;
            found_count  <= '0;
        end else begin
            new_result <= push;
            if (honoured & full & ~pop) begin
                overflow <= 1'b1;
            end
            if (push && (found_count != 16'hFFFF)) begin
                found_count <= found_count + 16'd1;
            end

            case (fill)
                2'd0: begin
                    if (push) begin
                        result_nonce <= nonce_in;
                        result_valid <= 1'b1;
                        fill         <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push & pop) begin
                        result_nonce <= nonce_in;
                    end else if (push) begin
                        tail <= nonce_in;
                        fill <= 2'd2;
                    end else if (pop) begin
                        result_valid <= 1'b0;
                        fill         <= 2'd0;
                    end
                end
                default: begin
                    // When full, a push can only happen alongside a pop.
                    if (pop) begin
                        result_nonce <= tail;
                        if (push) begin
                            tail <= nonce_in;
                        end else begin
                            fill <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miner_event_gen.sv
// Testbench for miner_event_gen: directed scenarios plus random traffic against
// a queue-based behavioural model of jobs, watchdog and result buffer.
module tb_miner_event_gen;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned LOAD    = 4;

    logic               clk;
    logic               reset;
    logic               work_valid;
    logic               work_ready;
    logic               nonce_found;
    logic [NONCE_W-1:0] nonce_in;
    logic               range_done;
    logic               result_valid;
    logic [NONCE_W-1:0] result_nonce;
    logic               result_ready;
    logic               new_work;
    logic               new_result;
    logic               hashing;
    logic               overflow;
    logic [15:0]        found_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit                 m_active;
    int                 m_age;
    int                 m_since_accept;
    bit                 m_ready;
    logic [NONCE_W-1:0] m_q[$];
    bit                 m_overflow;
    int                 m_count;
    bit                 m_new_work;
    bit                 m_new_result;

    miner_event_gen #(
        .NONCE_W        (NONCE_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LOAD_CYCLES    (LOAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .work_valid   (work_valid),
        .work_ready   (work_ready),
        .nonce_found  (nonce_found),
        .nonce_in     (nonce_in),
        .range_done   (range_done),
        .result_valid (result_valid),
        .result_nonce (result_nonce),
        .result_ready (result_ready),
        .new_work     (new_work),
        .new_result   (new_result),
        .hashing      (hashing),
        .overflow     (overflow),
        .found_count  (found_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_active       = 1'b0;
        m_age          = 0;
        m_since_accept = LOAD + 1;
        m_ready        = 1'b0;
        m_q.delete();
        m_overflow     = 1'b0;
        m_count        = 0;
        m_new_work     = 1'b0;
        m_new_result   = 1'b0;
    endtask

    task automatic drive(input logic wv, input logic nf, input logic [NONCE_W-1:0] nin,
                         input logic rd, input logic rr);
        work_valid   = wv;
        nonce_found  = nf;
        nonce_in     = nin;
        range_done   = rd;
        result_ready = rr;
    endtask

    // Advance the model by one cycle using the driven inputs, then clock the DUT.
    task automatic step();
        bit acc;
        bit pop;
        bit hon;
        acc = (work_valid === 1'b1) && m_ready;
        pop = (m_q.size() != 0) && (result_ready === 1'b1);
        hon = (nonce_found === 1'b1) && (m_active || acc);
        if (pop) void'(m_q.pop_front());
        m_new_result = 1'b0;
        if (hon) begin
            if (m_q.size() < 2) begin
                m_q.push_back(nonce_in);
                m_new_result = 1'b1;
                if (m_count < 65535) m_count++;
            end else begin
                m_overflow = 1'b1;
            end
        end
        m_new_work = acc;
        if (acc) begin
            m_active       = 1'b1;
            m_age          = 1;
            m_since_accept = 1;
        end else begin
            if (m_since_accept <= LOAD) m_since_accept++;
            if (m_active) begin
                if (range_done === 1'b1) begin
                    m_active = 1'b0;
                end else begin
                    m_age++;
                    if (m_age > TIMEOUT) m_active = 1'b0;
                end
            end
        end
        m_ready = (m_since_accept > LOAD);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        drive(0, 0, '0, 0, 0);
        while (!m_ready && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (work_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: work_ready=%b want 1 after %0d cycles", work_ready, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, '0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({work_ready, new_work, new_result, hashing, overflow, result_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {work_ready, new_work, new_result, hashing, overflow, result_valid});
        end
        checks++;
        if (result_nonce !== '0 || found_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: nonce=%h count=%0d want 0/0", result_nonce, found_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (work_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: work_ready=%b want 1", work_ready);
        end
    endtask

    task automatic test_accept();
        drive(1, 0, '0, 0, 0);
        step();
        checks++;
        if (new_work !== 1'b1 || hashing !== 1'b1 || work_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_first: new_work=%b hashing=%b ready=%b want 1/1/0",
                     new_work, hashing, work_ready);
        end
        drive(0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (new_work !== 1'b0 || work_ready !== 1'b0 || hashing !== 1'b1) begin
                errors++;
                $display("FAIL accept_load[%0d]: new_work=%b ready=%b hashing=%b want 0/0/1",
                         i, new_work, work_ready, hashing);
            end
        end
        step();
        checks++;
        if (work_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready_back: work_ready=%b want 1", work_ready);
        end
    endtask

    task automatic test_single_nonce();
        drive(0, 1, 32'hDEADBEEF, 0, 0);
        step();
        checks++;
        if (new_result !== 1'b1 || result_valid !== 1'b1 || result_nonce !== 32'hDEADBEEF
            || found_count !== 16'd1) begin
            errors++;
            $display("FAIL single_store: pulse=%b valid=%b nonce=%h count=%0d want 1/1/deadbeef/1",
                     new_result, result_valid, result_nonce, found_count);
        end
        drive(0, 0, '0, 0, 0);
        step();
        checks++;
        if (new_result !== 1'b0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse_once: pulse=%b valid=%b want 0/1", new_result, result_valid);
        end
        drive(0, 0, '0, 0, 1);
        step();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: valid=%b want 0", result_valid);
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_push_pop_full();
        drive(0, 1, 32'hB0000001, 0, 0);
        step();
        drive(0, 1, 32'hB0000002, 0, 0);
        step();
        drive(0, 1, 32'hB0000003, 0, 1);
        step();
        checks++;
        if (new_result !== 1'b1 || overflow !== 1'b0 || result_valid !== 1'b1
            || result_nonce !== 32'hB0000002) begin
            errors++;
            $display("FAIL full_push_pop: pulse=%b ovf=%b valid=%b nonce=%h want 1/0/1/b0000002",
                     new_result, overflow, result_valid, result_nonce);
        end
        checks++;
        if (found_count !== 16'(m_count)) begin
            errors++;
            $display("FAIL full_count: count=%0d want %0d", found_count, m_count);
        end
        drive(0, 0, '0, 0, 1);
        step();
        checks++;
        if (result_valid !== 1'b1 || result_nonce !== 32'hB0000003) begin
            errors++;
            $display("FAIL full_tail: valid=%b nonce=%h want 1/b0000003", result_valid, result_nonce);
        end
        step();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: valid=%b want 0", result_valid);
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_overflow();
        drive(0, 1, 32'hA0000001, 0, 0);
        step();
        drive(0, 1, 32'hA0000002, 0, 0);
        step();
        drive(0, 1, 32'hA0000003, 0, 0);
        step();
        checks++;
        if (new_result !== 1'b0 || overflow !== 1'b1 || result_nonce !== 32'hA0000001) begin
            errors++;
            $display("FAIL ovf_drop: pulse=%b ovf=%b nonce=%h want 0/1/a0000001",
                     new_result, overflow, result_nonce);
        end
        checks++;
        if (found_count !== 16'(m_count)) begin
            errors++;
            $display("FAIL ovf_count: count=%0d want %0d", found_count, m_count);
        end
        drive(0, 0, '0, 0, 1);
        step();
        checks++;
        if (result_valid !== 1'b1 || result_nonce !== 32'hA0000002) begin
            errors++;
            $display("FAIL ovf_pop_a2: valid=%b nonce=%h want 1/a0000002", result_valid, result_nonce);
        end
        step();
        checks++;
        if (result_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained: valid=%b ovf=%b want 0/1", result_valid, overflow);
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_range_done();
        drive(0, 0, '0, 1, 0);
        step();
        checks++;
        if (hashing !== 1'b0) begin
            errors++;
            $display("FAIL rd_exhaust: hashing=%b want 0", hashing);
        end
        drive(0, 1, 32'hC0000001, 0, 0);
        step();
        checks++;
        if (new_result !== 1'b0 || result_valid !== 1'b0 || found_count !== 16'(m_count)) begin
            errors++;
            $display("FAIL rd_nonce_ignored: pulse=%b valid=%b count=%0d want 0/0/%0d",
                     new_result, result_valid, found_count, m_count);
        end
        drive(0, 0, '0, 1, 0);
        step();
        checks++;
        if (hashing !== 1'b0) begin
            errors++;
            $display("FAIL rd_outside: hashing=%b want 0", hashing);
        end
        wait_ready();
        drive(1, 0, '0, 0, 0);
        step();
        checks++;
        if (hashing !== 1'b1 || new_work !== 1'b1) begin
            errors++;
            $display("FAIL rd_restart: hashing=%b new_work=%b want 1/1", hashing, new_work);
        end
        wait_ready();
        drive(1, 0, '0, 1, 0);
        step();
        drive(0, 0, '0, 0, 0);
        step();
        checks++;
        if (hashing !== 1'b1 || new_work !== 1'b0) begin
            errors++;
            $display("FAIL rd_accept_wins: hashing=%b new_work=%b want 1/0", hashing, new_work);
        end
        wait_ready();
        drive(1, 1, 32'hD0000001, 0, 0);
        step();
        checks++;
        if (new_work !== 1'b1 || new_result !== 1'b1 || result_nonce !== 32'hD0000001) begin
            errors++;
            $display("FAIL accept_and_nonce: new_work=%b pulse=%b nonce=%h want 1/1/d0000001",
                     new_work, new_result, result_nonce);
        end
        drive(0, 0, '0, 0, 1);
        step();
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_timeout();
        wait_ready();
        drive(1, 0, '0, 0, 0);
        step();
        drive(0, 0, '0, 0, 0);
        for (int i = 2; i <= TIMEOUT + 1; i++) begin
            step();
            checks++;
            if (hashing !== (i <= TIMEOUT)) begin
                errors++;
                $display("FAIL timeout[%0d]: hashing=%b want %b", i, hashing, (i <= TIMEOUT));
            end
        end
        drive(0, 1, 32'hE0000009, 0, 0);
        step();
        checks++;
        if (new_result !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle_nonce: pulse=%b want 0", new_result);
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), $urandom(),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 5));
            step();
            checks++;
            if (work_ready !== m_ready || new_work !== m_new_work || hashing !== m_active) begin
                errors++;
                $display("FAIL rnd_job[%0d]: ready/new_work/hashing=%b%b%b want %b%b%b",
                         c, work_ready, new_work, hashing, m_ready, m_new_work, m_active);
            end
            checks++;
            if (new_result !== m_new_result || overflow !== m_overflow
                || found_count !== 16'(m_count)) begin
                errors++;
                $display("FAIL rnd_result[%0d]: pulse/ovf=%b%b count=%0d want %b%b %0d",
                         c, new_result, overflow, found_count, m_new_result, m_overflow, m_count);
            end
            checks++;
            if (result_valid !== (m_q.size() != 0)
                || (m_q.size() != 0 && result_nonce !== m_q[0])) begin
                errors++;
                $display("FAIL rnd_fifo[%0d]: valid=%b nonce=%h want valid=%b depth=%0d",
                         c, result_valid, result_nonce, (m_q.size() != 0), m_q.size());
            end
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_reset_mid();
        wait_ready();
        drive(1, 0, '0, 0, 0);
        step();
        drive(0, 1, 32'hF0000001, 0, 0);
        step();
        checks++;
        if (result_valid !== 1'b1 || hashing !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: valid=%b hashing=%b want 1/1", result_valid, hashing);
        end
        drive(0, 0, '0, 0, 0);
        reset = 1'b1;
        #1;
        checks++;
        if ({work_ready, new_work, new_result, hashing, overflow, result_valid} !== 6'b0
            || result_nonce !== '0 || found_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b nonce=%h count=%0d want all 0",
                     {work_ready, new_work, new_result, hashing, overflow, result_valid},
                     result_nonce, found_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        checks++;
        if (work_ready !== 1'b1 || hashing !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: ready=%b hashing=%b valid=%b want 1/0/0",
                     work_ready, hashing, result_valid);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_single_nonce();
        test_push_pop_full();
        test_overflow();
        test_range_done();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
